// File: rtl/mpc_bank_arb.sv
// Round-robin request arbiter in front of the bank hit-test stage, with write-buffer id allocation.
// Optional MPC_WBUF_FREE_CHECK_EN: ignore and flag releases of ids that are already free.
module mpc_bank_arb #(
  parameter int unsigned NCH        = 3,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned WBUF_DEPTH = 128,
  parameter int unsigned WBUF_W     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        ch_req_valid,
  output logic [NCH-1:0]        ch_req_ready,
  input  logic [3*NCH-1:0]      ch_req_op,
  input  logic [ADDR_W*NCH-1:0] ch_req_addr,
  input  logic [DATA_W*NCH-1:0] ch_req_wdata,
  output logic                  d_bank_req_valid,
  input  logic                  d_bank_req_ready,
  output logic [NCH-1:0]        d_bank_req_channel_1hot_id,
  output logic [2:0]            d_bank_req_op,
  output logic [ADDR_W-1:0]     d_bank_req_addr,
  output logic [DATA_W-1:0]     d_bank_req_wdata,
  output logic [WBUF_W-1:0]     d_bank_req_wbuf_id,
  input  logic                  u_wbuf_free_valid,
  input  logic [WBUF_W-1:0]     u_wbuf_free_id,
  output logic [WBUF_W:0]       wbuf_free_cnt,
  output logic                  err_dbl_free
);

  localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CNT_W = WBUF_W + 1;
  localparam logic [2:0]  OP_WR = 3'd2;

  logic [PTR_W-1:0]      rr_q, rr_d;
  logic [WBUF_DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  valid_q;
  logic [NCH-1:0]        oh_q;
  logic [2:0]            op_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [WBUF_W-1:0]     wbuf_id_q;

  logic                  load_c;
  logic                  any_free_c;
  logic [WBUF_W-1:0]     free_id_c;
  logic [NCH-1:0]        elig_c;
  logic                  grant_c;
  logic [PTR_W-1:0]      grant_idx_c;
  logic [NCH-1:0]        grant_oh_c;
  logic [2:0]            gnt_op_c;
  logic [ADDR_W-1:0]     gnt_addr_c;
  logic [DATA_W-1:0]     gnt_wdata_c;
  logic                  alloc_c;
  logic                  rel_c;

  // Output register can take a new request when empty or draining this cycle.
  assign load_c     = !valid_q || d_bank_req_ready;
  assign any_free_c = |(~busy_q);

  // Lowest-index free id; a release in this cycle is not yet visible in busy_q.
  always_comb begin
    free_id_c = '0;
    for (int i = int'(WBUF_DEPTH) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_id_c = WBUF_W'(i);
    end
  end

  always_comb begin
    elig_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      elig_c[i] = ch_req_valid[i] && ((ch_req_op[3*i +: 3] != OP_WR) || any_free_c);
    end
  end

  // Round-robin search starting at rr_q.
  always_comb begin
    int idx;
    idx         = 0;
    grant_c     = 1'b0;
    grant_idx_c = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      idx = (int'(rr_q) + k) % int'(NCH);
      if (!rst && load_c && !grant_c && elig_c[PTR_W'(idx)]) begin
        grant_c     = 1'b1;
        grant_idx_c = PTR_W'(idx);
      end
    end
    grant_oh_c = '0;
    if (grant_c) grant_oh_c[grant_idx_c] = 1'b1;
  end

  always_comb begin
    gnt_op_c    = '0;
    gnt_addr_c  = '0;
    gnt_wdata_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (grant_oh_c[i]) begin
        gnt_op_c    = ch_req_op[3*i +: 3];
        gnt_addr_c  = ch_req_addr[ADDR_W*i +: ADDR_W];
        gnt_wdata_c = ch_req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign alloc_c      = grant_c && (gnt_op_c == OP_WR);
  assign ch_req_ready = grant_oh_c;

`ifdef MPC_WBUF_FREE_CHECK_EN
  logic err_q;
  logic dbl_c;
  assign rel_c        = u_wbuf_free_valid &&  busy_q[u_wbuf_free_id];
  assign dbl_c        = u_wbuf_free_valid && !busy_q[u_wbuf_free_id];
  assign err_dbl_free = err_q;

  always_ff @(posedge clk) begin
    if (rst)        err_q <= 1'b0;
    else if (dbl_c) err_q <= 1'b1;
  end
`else
  assign rel_c        = u_wbuf_free_valid;
  assign err_dbl_free = 1'b0;
`endif

  // Release first so an allocation of the same id in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (rel_c)   busy_d[u_wbuf_free_id] = 1'b0;
    if (alloc_c) busy_d[free_id_c]      = 1'b1;
    cnt_d = cnt_q - CNT_W'(alloc_c) + CNT_W'(rel_c);
    rr_d  = rr_q;
    if (grant_c) rr_d = (grant_idx_c == PTR_W'(NCH - 1)) ? '0 : grant_idx_c + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= '0;
      busy_q    <= '0;
      cnt_q     <= CNT_W'(WBUF_DEPTH);
      valid_q   <= 1'b0;
      oh_q      <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wbuf_id_q <= '0;
    end else begin
      rr_q   <= rr_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (load_c) begin
        valid_q <= grant_c;
        if (grant_c) begin
          oh_q      <= grant_oh_c;
          op_q      <= gnt_op_c;
          addr_q    <= gnt_addr_c;
          wdata_q   <= gnt_wdata_c;
          wbuf_id_q <= alloc_c ? free_id_c : '0;
        end
      end
    end
  end

  assign d_bank_req_valid           = valid_q;
  assign d_bank_req_channel_1hot_id = oh_q;
  assign d_bank_req_op              = op_q;
  assign d_bank_req_addr            = addr_q;
  assign d_bank_req_wdata           = wdata_q;
  assign d_bank_req_wbuf_id         = wbuf_id_q;
  assign wbuf_free_cnt              = cnt_q;

endmodule
